// File: rtl/pong_pkg.sv
// Shared types and constants for the pong frame scheduler: phase encoding and
// the one-hot bit positions of the per-unit start/done handshake.
package pong_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_PADDLE,
    PH_BALL,
    PH_COLLIDE,
    PH_SCORE
  } phase_e;

  localparam int unsigned NUM_PHASES = 4;

  localparam int unsigned PH_PADDLE_BIT  = 0;
  localparam int unsigned PH_BALL_BIT    = 1;
  localparam int unsigned PH_COLLIDE_BIT = 2;
  localparam int unsigned PH_SCORE_BIT   = 3;

  // One-hot handshake lane of a phase; IDLE owns no lane.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(phase_e ph);
    logic [NUM_PHASES-1:0] oh;
    oh = '0;
    case (ph)
      PH_PADDLE:  oh[PH_PADDLE_BIT]  = 1'b1;
      PH_BALL:    oh[PH_BALL_BIT]    = 1'b1;
      PH_COLLIDE: oh[PH_COLLIDE_BIT] = 1'b1;
      PH_SCORE:   oh[PH_SCORE_BIT]   = 1'b1;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/game_phase_sequencer_if.sv
// Bundle between the frame scheduler and the pong datapath: game tick, pause,
// per-unit start/done handshake and the frame/overrun status.
interface game_phase_sequencer_if #(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned OVR_W   = 8
);
  import pong_pkg::*;

  logic                  tick_in;
  logic                  pause;
  logic [NUM_PHASES-1:0] phase_done;
  logic [NUM_PHASES-1:0] phase_start;
  logic                  busy;
  logic                  frame_done;
  logic [FRAME_W-1:0]    frame_count;
  logic                  overrun;
  logic [OVR_W-1:0]      overrun_count;
  logic                  timeout_err;

  // Scheduler side.
  modport master (
    input  tick_in,
    input  pause,
    input  phase_done,
    output phase_start,
    output busy,
    output frame_done,
    output frame_count,
    output overrun,
    output overrun_count,
    output timeout_err
  );

  // Datapath / environment side.
  modport slave (
    output tick_in,
    output pause,
    output phase_done,
    input  phase_start,
    input  busy,
    input  frame_done,
    input  frame_count,
    input  overrun,
    input  overrun_count,
    input  timeout_err
  );

endinterface

// File: rtl/phase_watchdog.sv
// Per-phase wait counter: cleared on phase entry, counts while a phase waits,
// flags expiry on the TIMEOUT_CYC-th cycle. Used only with PHASE_TIMEOUT_EN.
module phase_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Entry cycle holds 0, so LastCnt is the TIMEOUT_CYC-th cycle in the phase.
  assign expired = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_phase_sequencer.sv
// Pong frame scheduler: one paddle/ball/collide/score pass per game tick rise,
// with frame and overrun counters. Optional per-phase watchdog: PHASE_TIMEOUT_EN.
module game_phase_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned OVR_W   = 8
`ifdef PHASE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  game_phase_sequencer_if.master bus
);

  phase_e                state_q, state_d;
  logic                  tick_q;
  logic                  tick_rise;
  logic                  busy;
  logic                  cur_done;
  logic                  timeout_hit;
  logic [NUM_PHASES-1:0] phase_start_q, phase_start_d;
  logic                  frame_done_q, frame_done_d;
  logic [FRAME_W-1:0]    frame_count_q, frame_count_d;
  logic                  overrun_q, overrun_d;
  logic [OVR_W-1:0]      overrun_count_q, overrun_count_d;

  assign tick_rise = bus.tick_in & ~tick_q;
  assign busy      = (state_q != PH_IDLE);
  // Only the current phase's done lane matters; IDLE selects no lane.
  assign cur_done  = |(bus.phase_done & phase_onehot(state_q));

`ifdef PHASE_TIMEOUT_EN
  logic wd_expired;
  logic timeout_err_q;

  phase_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_phase_watchdog (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .load    (state_d != state_q),
    .count_en(busy),
    .expired (wd_expired)
  );

  // A done on the limit cycle wins over expiry.
  assign timeout_hit = busy & wd_expired & ~cur_done;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    phase_start_d   = '0;
    frame_done_d    = 1'b0;
    frame_count_d   = frame_count_q;
    overrun_d       = 1'b0;
    overrun_count_d = overrun_count_q;

    case (state_q)
      PH_IDLE: begin
        if (tick_rise && !bus.pause) begin
          state_d = PH_PADDLE;
        end
      end
      PH_PADDLE: begin
        if (cur_done) state_d = PH_BALL;
      end
      PH_BALL: begin
        if (cur_done) state_d = PH_COLLIDE;
      end
      PH_COLLIDE: begin
        if (cur_done) state_d = PH_SCORE;
      end
      PH_SCORE: begin
        if (cur_done) begin
          state_d       = PH_IDLE;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
        end
      end
      default: state_d = PH_IDLE;
    endcase

    if (timeout_hit) begin
      state_d = PH_IDLE;
    end

    // Start pulse lands on the first cycle of the phase being entered.
    if ((state_d != state_q) && (state_d != PH_IDLE)) begin
      phase_start_d = phase_onehot(state_d);
    end

    // Ticks while busy (including the final SCORE cycle) are dropped, not queued.
    if (tick_rise && busy) begin
      overrun_d = 1'b1;
      if (overrun_count_q != {OVR_W{1'b1}}) begin
        overrun_count_d = overrun_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= PH_IDLE;
      tick_q          <= 1'b0;
      phase_start_q   <= '0;
      frame_done_q    <= 1'b0;
      frame_count_q   <= '0;
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      state_q         <= state_d;
      tick_q          <= bus.tick_in;
      phase_start_q   <= phase_start_d;
      frame_done_q    <= frame_done_d;
      frame_count_q   <= frame_count_d;
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign bus.phase_start   = phase_start_q;
  assign bus.busy          = busy;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_count   = frame_count_q;
  assign bus.overrun       = overrun_q;
  assign bus.overrun_count = overrun_count_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Directed bench for game_phase_sequencer with a start/frame scoreboard and a
// unit responder model. Watchdog checks are built only with PHASE_TIMEOUT_EN.
module tb_game_phase_sequencer;

  localparam int unsigned FW = 8;  // narrow frame counter keeps the wrap test short
  localparam int unsigned OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  initial forever #5 clk = ~clk;

  game_phase_sequencer_if #(.FRAME_W(FW), .OVR_W(OW)) bus ();

  game_phase_sequencer #(
    .FRAME_W(FW),
    .OVR_W  (OW)
`ifdef PHASE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [3:0]  exp_start_q[$];
  logic [31:0] exp_fc_q[$];
  int frames = 0;
  int ovr_exp = 0;

  int start_seen = 0;
  int done_seen = 0;
  int ovr_seen = 0;
  int cyc_n = 0;
  int cyc_start2 = 0;
  int cyc_idle = 0;
  logic busy_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (bus.phase_start != 4'b0000) begin
        start_seen++;
        if (bus.phase_start == 4'b0100) cyc_start2 = cyc_n;
        if (exp_start_q.size() == 0) chk("unexpected_start", 32'(bus.phase_start), 32'd0);
        else chk("start_order", 32'(bus.phase_start), 32'(exp_start_q.pop_front()));
      end
      if (bus.frame_done) begin
        done_seen++;
        if (exp_fc_q.size() == 0) chk("unexpected_frame_done", 32'(bus.frame_done), 32'd0);
        else chk("frame_count_at_done", 32'(bus.frame_count), exp_fc_q.pop_front());
      end
      if (bus.overrun) ovr_seen++;
      if (busy_prev && !bus.busy) cyc_idle = cyc_n;
      busy_prev = bus.busy;
    end
  end

  // Unit model: done pulses `delay` cycles after start unless its lane is blocked.
  logic [3:0] block = 4'b0000;
  int unsigned delay = 0;

  initial begin
    int unsigned rem[4];
    logic [3:0] pend;
    logic [3:0] nd;
    pend = 4'b0000;
    bus.phase_done = 4'b0000;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (bus.phase_start[i]) begin
          pend[i] = 1'b1;
          rem[i] = delay;
        end else if (pend[i] && rem[i] != 0) begin
          rem[i] = rem[i] - 1;
        end
        nd[i] = pend[i] && (rem[i] == 0) && !block[i];
        if (nd[i]) pend[i] = 1'b0;
      end
      bus.phase_done = nd;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame();
    exp_start_q.push_back(4'b0001);
    exp_start_q.push_back(4'b0010);
    exp_start_q.push_back(4'b0100);
    exp_start_q.push_back(4'b1000);
    frames++;
    exp_fc_q.push_back(32'(frames % (1 << FW)));
  endtask

  task automatic tick();
    bus.tick_in = 1'b1;
    cyc(1);
    bus.tick_in = 1'b0;
    cyc(1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int st0, ov0, dn0;
    bus.tick_in = 1'b0;
    bus.pause = 1'b0;

    // Reset
    rst_n = 1'b0;
    cyc(5);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_phase_start", 32'(bus.phase_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_overrun_count", 32'(bus.overrun_count), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

    // One frame, units answer 3 cycles after each start
    delay = 3;
    dn0 = done_seen;
    push_frame();
    bus.tick_in = 1'b1;
    cyc(1);
    chk("start_latency", 32'(bus.phase_start), 32'd1);
    bus.tick_in = 1'b0;
    cyc(1);
    wait_idle("frame1_idle", 100);
    chk("frame1_count", 32'(bus.frame_count), 32'd1);
    chk("frame1_done_once", 32'(done_seen - dn0), 32'd1);

    // Pause blocks new frames
    delay = 0;
    bus.pause = 1'b1;
    st0 = start_seen;
    repeat (3) begin
      tick();
      cyc(2);
    end
    chk("pause_busy", 32'(bus.busy), 32'd0);
    chk("pause_no_start", 32'(start_seen - st0), 32'd0);
    chk("pause_overrun", 32'(ovr_seen), 32'd0);
    bus.pause = 1'b0;
    push_frame();
    tick();
    wait_idle("unpause_idle", 100);
    chk("unpause_count", 32'(bus.frame_count), 32'(frames));

    // Tick rise coinciding with SCORE->IDLE is an overrun and is dropped
    block = 4'b1000;
    push_frame();
    tick();
    cyc(4);
    chk("score_wait_busy", 32'(bus.busy), 32'd1);
    st0 = start_seen;
    ov0 = ovr_seen;
    block = 4'b0000;
    cyc(1);
    bus.tick_in = 1'b1;
    cyc(1);
    bus.tick_in = 1'b0;
    cyc(3);
    ovr_exp = ovr_exp + 1;
    chk("edge_overrun_pulse", 32'(ovr_seen - ov0), 32'd1);
    chk("edge_overrun_count", 32'(bus.overrun_count), 32'(ovr_exp));
    chk("edge_no_new_frame", 32'(start_seen - st0), 32'd0);
    chk("edge_idle", 32'(bus.busy), 32'd0);
    chk("edge_frame_count", 32'(bus.frame_count), 32'(frames));

    // 300 ticks while stuck in BALL: overrun saturates, frame survives
    block = 4'b0010;
    push_frame();
    tick();
    cyc(2);
    chk("ball_stuck_busy", 32'(bus.busy), 32'd1);
    st0 = start_seen;
    ov0 = ovr_seen;
    repeat (300) tick();
    cyc(2);
    ovr_exp = (ovr_exp + 300 > 255) ? 255 : ovr_exp + 300;
    chk("ovr_pulses", 32'(ovr_seen - ov0), 32'd300);
    chk("ovr_saturated", 32'(bus.overrun_count), 32'(ovr_exp));
    chk("ovr_no_restart", 32'(start_seen - st0), 32'd0);
    block = 4'b0000;
    wait_idle("ovr_frame_idle", 100);
    chk("ovr_frame_count", 32'(bus.frame_count), 32'(frames));

`ifdef PHASE_TIMEOUT_EN
    // Watchdog: collide unit never answers
    block = 4'b0100;
    exp_start_q.push_back(4'b0001);
    exp_start_q.push_back(4'b0010);
    exp_start_q.push_back(4'b0100);
    dn0 = done_seen;
    tick();
    wait_idle("wd_idle", 100);
    chk("wd_latency", 32'(cyc_idle - cyc_start2), 32'd16);
    chk("wd_err", 32'(bus.timeout_err), 32'd1);
    chk("wd_no_frame_done", 32'(done_seen - dn0), 32'd0);
    chk("wd_frame_count", 32'(bus.frame_count), 32'(frames));
    block = 4'b0000;
    cyc(3);
    push_frame();
    tick();
    wait_idle("wd_after_idle", 100);
    chk("wd_err_sticky", 32'(bus.timeout_err), 32'd1);
`else
    chk("no_wd_err", 32'(bus.timeout_err), 32'd0);
`endif

    // Reset in the middle of BALL aborts the frame at once
    block = 4'b0010;
    exp_start_q.push_back(4'b0001);
    exp_start_q.push_back(4'b0010);
    tick();
    cyc(1);
    chk("mid_reset_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_start", 32'(bus.phase_start), 32'd0);
    chk("mid_reset_frame_count", 32'(bus.frame_count), 32'd0);
    chk("mid_reset_overrun_count", 32'(bus.overrun_count), 32'd0);
    chk("mid_reset_timeout_err", 32'(bus.timeout_err), 32'd0);
    cyc(2);
    block = 4'b0000;
    frames = 0;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);

    // Run to all-ones, then wrap
    for (int f = 0; f < (1 << FW) - 1; f++) begin
      push_frame();
      tick();
      wait_idle("wrap_run_idle", 50);
    end
    chk("wrap_all_ones", 32'(bus.frame_count), 32'((1 << FW) - 1));
    push_frame();
    tick();
    wait_idle("wrap_last_idle", 50);
    chk("wrap_zero", 32'(bus.frame_count), 32'd0);
    chk("wrap_overrun_count", 32'(bus.overrun_count), 32'd0);

    cyc(3);
    chk("sb_starts_drained", 32'(exp_start_q.size()), 32'd0);
    chk("sb_frames_drained", 32'(exp_fc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
